hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline-control block for the RV32IC core. It produces the stall, bubble and flush signals that forwarding alone cannot cover: load-use RAW hazards, data-memory wait states and EX-stage control-flow redirects. It keeps its own registered shadow of the ID/EX and EX/MEM destination information and sits beside the decode stage. It also keeps saturating performance counters for stall and flush events.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock; every register updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  ID source registers.
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1 / rs2.
- id_rd  in  5  ID destination register.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- mem_busy  in  1  data memory not ready; MEM stage must hold.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- pc_hold  out  1  PC must not update.
- ifid_hold  out  1  IF/ID register must not update.
- ifid_flush  out  1  IF/ID register must load a bubble.
- idex_bubble  out  1  ID/EX register must load a bubble.
- pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB must not update.
- hz_state  out  2  cause of this cycle's action: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT, 3 FLUSH.
- load_stall_cnt  out  CNT_W  count of LOAD_STALL cycles.
- flush_cnt  out  CNT_W  count of FLUSH cycles.

## Operation
- Shadow slots: ex_slot and mem_slot. Each holds {valid, rd, reg_write, mem_read}.
- load_use is asserted when all of the following hold:
  - id_valid & ex_slot.valid & ex_slot.mem_read & ex_slot.rd != 0
  - (id_use_rs1 & id_rs1 == ex_slot.rd) | (id_use_rs2 & id_rs2 == ex_slot.rd)
- A load in mem_slot never causes a stall; MEM/WB forwarding covers it.
- Priority, evaluated combinationally each cycle:
  - MEM_WAIT (mem_busy): pc_hold = ifid_hold = pipe_hold = 1; idex_bubble = ifid_flush = 0.
  - FLUSH (ex_redirect): ifid_flush = idex_bubble = 1; holds = 0.
  - LOAD_STALL (load_use): pc_hold = ifid_hold = idex_bubble = 1; pipe_hold = 0.
  - RUN: all controls 0.
- Only the highest-priority cause acts. A redirect that coincides with mem_busy is deferred; upstream keeps ex_redirect asserted because EX is held.
- Slot update on each rising edge:
  - MEM_WAIT: both slots hold.
  - FLUSH or LOAD_STALL: mem_slot <= ex_slot; ex_slot <= invalid.
  - RUN: mem_slot <= ex_slot; ex_slot <= {id_valid, id_rd, id_reg_write, id_mem_read}.
- Counters increment by 1 on each LOAD_STALL / FLUSH cycle and saturate at all-ones (no wrap).
- rd == 0 never produces a hazard.

## Timing
- All controls and hz_state are combinational from the current slots and inputs. There is no added latency; they are valid in the same cycle as the inputs.
- A load-use hazard costs exactly 1 stall cycle. The next cycle returns to RUN because ex_slot is then a bubble.
- A redirect costs 1 FLUSH cycle. The following cycle is RUN unless mem_busy or a new hazard is present.
- mem_busy held for N cycles gives N MEM_WAIT cycles. A LOAD_STALL pending behind it takes effect in the first cycle mem_busy is low.
- Reset (asynchronous, any time, including mid-stall): slots invalid, counters 0, hz_state = RUN. All outputs are 0 while rst_n is low and afterwards until the inputs create a hazard.

## Structure
- hazard_pkg holds:
  - state encodings HZ_RUN / HZ_LOAD_STALL / HZ_MEM_WAIT / HZ_FLUSH
  - the slot field layout and widths
  - the default CNT_W
- One sub-module, hz_sat_counter (enable, saturating, async active-low reset), instantiated twice.
- The slot registers and the priority logic stay in hazard_unit.

## Test plan
- Load-use stall:
  - Stimulus: issue a load x5 (id_mem_read = 1, id_rd = 5), then on the next cycle an add reading rs1 = 5.
  - Required: one cycle with hz_state = 1, pc_hold = ifid_hold = idex_bubble = 1; then RUN; load_stall_cnt = 1.
- No stall on distance 2 or on x0:
  - Stimulus: load x5, an unrelated instruction, then a read of x5; separately, load x0 followed by a read of x0.
  - Required: hz_state stays 0; counter stays 0.
- mem_busy during load-use:
  - Stimulus: raise mem_busy for 3 cycles in the cycle a load-use would occur.
  - Required: 3 MEM_WAIT cycles with pipe_hold = 1 and slots unchanged; then 1 LOAD_STALL cycle; then RUN.
- Redirect over load-use:
  - Stimulus: ex_redirect = 1 in the same cycle as load_use.
  - Required: hz_state = 3, ifid_flush = idex_bubble = 1, pc_hold = 0; flush_cnt += 1; load_stall_cnt unchanged; next cycle RUN.
- Saturation:
  - Stimulus: with CNT_W = 4, produce 20 redirects.
  - Required: flush_cnt = 15 and holds at 15.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 asynchronously during a MEM_WAIT with a load in ex_slot; release it, then apply a dependent read with mem_busy = 0.
  - Required: all outputs 0 immediately on assertion; counters 0; no stall after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the RV32IC pipeline hazard unit: action encodings,
// the shadow-slot layout and the default performance-counter width.
package hazard_pkg;

  localparam int REG_W         = 5;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_MEM_WAIT   = 2'd2,
    HZ_FLUSH      = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hz_sat_counter.sv
// Enable-driven up-counter that sticks at all-ones instead of wrapping.
module hz_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall / bubble / flush control beside the decode stage, with registered
// shadows of the ID/EX and EX/MEM destinations and saturating event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             mem_busy,
  input  logic             ex_redirect,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  slot_t     ex_slot, mem_slot;
  hz_state_e state;
  logic      load_use;

  // Only a load sitting in EX stalls; a load already in MEM is forwarded.
  assign load_use = id_valid & ex_slot.valid & ex_slot.mem_read & (ex_slot.rd != '0)
                  & ((id_use_rs1 & (id_rs1 == ex_slot.rd))
                   | (id_use_rs2 & (id_rs2 == ex_slot.rd)));

  // NOTE: every output gets a default before the priority chain, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state       = HZ_RUN;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    // Controls are forced quiet while reset is held, even if mem_busy is high.
    if (rst_n) begin
      if (mem_busy) begin
        state     = HZ_MEM_WAIT;
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        pipe_hold = 1'b1;
      end else if (ex_redirect) begin
        state       = HZ_FLUSH;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        state       = HZ_LOAD_STALL;
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  assign hz_state = state;

  // NOTE: sequential state uses non-blocking assignments so mem_slot samples
  // the pre-edge ex_slot regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= SLOT_EMPTY;
      mem_slot <= SLOT_EMPTY;
    end else begin
      case (state)
        HZ_MEM_WAIT: begin
          ex_slot  <= ex_slot;
          mem_slot <= mem_slot;
        end
        HZ_FLUSH, HZ_LOAD_STALL: begin
          mem_slot <= ex_slot;
          ex_slot  <= SLOT_EMPTY;
        end
        default: begin
          mem_slot <= ex_slot;
          ex_slot  <= '{valid: id_valid, rd: id_rd,
                        reg_write: id_reg_write, mem_read: id_mem_read};
        end
      endcase
    end
  end

  // mem_slot and reg_write are tracked for visibility; no hazard depends on them.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{mem_slot, ex_slot.reg_write};

  hz_sat_counter #(.W(CNT_W)) u_load_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == HZ_LOAD_STALL),
    .count (load_stall_cnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == HZ_FLUSH),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized scoreboard bench for hazard_unit with a rule-level reference model.
module tb_hazard_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst_n;
  logic          id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          mem_busy, ex_redirect;
  logic          pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_hold;
  logic [1:0]    hz_state;
  logic [CW-1:0] load_stall_cnt, flush_cnt;

  hazard_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .mem_busy(mem_busy),
    .ex_redirect(ex_redirect), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .hz_state(hz_state), .load_stall_cnt(load_stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [4:0] ctl;   // {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_hold}
    int         st;
    int         lsc;
    int         fc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model: destination of a load currently in EX (-1 when none/x0),
  // plus the two event counts.
  int m_ex_ld = -1;
  int m_lsc   = 0;
  int m_fc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ctl_of(input int st);
    case (st)
      1:       return 5'b11010;
      2:       return 5'b11001;
      3:       return 5'b00110;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] ctl_now();
    return {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_hold};
  endfunction

  // Drive one cycle of ID-stage inputs, predict the response, advance the model.
  task automatic step(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                      input int rd, input bit rw, input bit mr, input bit busy, input bit redir);
    exp_t e;
    int   st;
    @(posedge clk); #1;
    id_valid = v; id_rs1 = r1[4:0]; id_rs2 = r2[4:0]; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd[4:0]; id_reg_write = rw; id_mem_read = mr; mem_busy = busy; ex_redirect = redir;
    if (busy) st = 2;
    else if (redir) st = 3;
    else if (v && m_ex_ld > 0 && ((u1 && r1 == m_ex_ld) || (u2 && r2 == m_ex_ld))) st = 1;
    else st = 0;
    e.st = st; e.ctl = ctl_of(st); e.lsc = m_lsc; e.fc = m_fc;
    exp_q.push_back(e);
    if (st == 1 && m_lsc < CMAX) m_lsc++;
    if (st == 3 && m_fc < CMAX) m_fc++;
    if (st == 0) m_ex_ld = (v && mr && rd != 0) ? rd : -1;
    else if (st != 2) m_ex_ld = -1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic load(input int rd);
    step(1, 0, 0, 0, 0, rd, 1, 1, 0, 0);
  endtask
  task automatic read_rs1(input int rs, input bit busy, input bit redir);
    step(1, rs, 0, 1, 0, 10, 1, 0, busy, redir);
  endtask

  // Monitor: the DUT presents a response every cycle; compare at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("controls", {27'd0, ctl_now()}, {27'd0, mon_e.ctl});
        check("hz_state", {30'd0, hz_state}, mon_e.st);
        check("load_stall_cnt", {28'd0, load_stall_cnt}, mon_e.lsc);
        check("flush_cnt", {28'd0, flush_cnt}, mon_e.fc);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; mem_busy = 1'b1; ex_redirect = 1'b1;
    #3;
    check("reset_controls", {27'd0, ctl_now()}, 0);
    check("reset_state", {30'd0, hz_state}, 0);
    check("reset_counters", {24'd0, load_stall_cnt, flush_cnt}, 0);
    mem_busy = 1'b0; ex_redirect = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle(); idle();
    // Load-use: one stall, then RUN with the instruction held in ID.
    load(5); read_rs1(5, 0, 0); read_rs1(5, 0, 0); idle();
    // Distance two, and x0, never stall.
    load(5); idle(); read_rs1(5, 0, 0);
    load(0); read_rs1(0, 0, 0); idle();
    // rs2 dependency.
    load(3); step(1, 0, 3, 0, 1, 11, 1, 0, 0, 0); step(1, 0, 3, 0, 1, 11, 1, 0, 0, 0);
    // Dependency present but not used.
    load(4); step(1, 4, 4, 0, 0, 11, 1, 0, 0, 0);
    // mem_busy over a pending load-use.
    load(7); repeat (3) read_rs1(7, 1, 0); read_rs1(7, 0, 0); read_rs1(7, 0, 0);
    // Redirect wins over load-use; redirect under mem_busy is deferred.
    load(9); read_rs1(9, 0, 1); idle();
    load(8); read_rs1(8, 1, 1); read_rs1(8, 0, 1); idle();

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom % 4, $urandom % 4, $urandom % 2, $urandom % 2,
           $urandom % 4, $urandom % 2, $urandom % 2, ($urandom % 5) == 0, ($urandom % 6) == 0);
    end

    // Saturation of the flush counter.
    repeat (20) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    @(negedge clk); #1;
    check("flush_saturated", {28'd0, flush_cnt}, CMAX);

    // Asynchronous reset during MEM_WAIT with a load in EX.
    load(6); read_rs1(6, 1, 0);
    #2;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("async_reset_controls", {27'd0, ctl_now()}, 0);
    check("async_reset_state", {30'd0, hz_state}, 0);
    check("async_reset_counters", {24'd0, load_stall_cnt, flush_cnt}, 0);
    m_ex_ld = -1; m_lsc = 0; m_fc = 0;
    @(posedge clk); #1;
    check("reset_held_controls", {27'd0, ctl_now()}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    read_rs1(6, 0, 0); idle();
    load(6); read_rs1(6, 0, 0); idle();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
